text_ram_arbiter: RTL and testbench

Shares the single-port character RAM between the display fetch path and a host (CPU/UART) read/write port. The display side is driven by the VGA timing generator's cell strobe and column/row indices, and always gets the next RAM slot. The host side uses a valid/ready request port with a one-entry holding register and receives read data on a tagged return path. The block sits between the VGA timing generator, the character RAM and the font/pixel serialiser.

---
 rtl/text_ram_pkg.sv | 29 ++
 rtl/cell_address.sv | 65 ++++++
 rtl/text_ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_text_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_ram_pkg
// Description : Shared constants and encodings for the text RAM arbiter.
// Revision    : 1.0
// ============================================================================
package text_ram_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 24;
    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] SPACE_CHAR = 8'h20;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_DISP    = 2'd1,
        SLOT_HOST_RD = 2'd2,
        SLOT_HOST_WR = 2'd3
    } slot_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_e;

endpackage
`default_nettype wire

// File: rtl/cell_address.sv
`default_nettype none
// ============================================================================
// Module      : cell_address
// Description : Registered row/column to linear RAM address with range check.
// Revision    : 1.0
// ============================================================================
module cell_address
    import text_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_fetch,
    input  logic [6:0]            i_col,
    input  logic [4:0]            i_row,
    output logic                  o_valid,
    output logic                  o_in_range,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam logic [6:0] c_cols = 7'(COLS);
    localparam logic [4:0] c_rows = 5'(ROWS);

    logic [ADDR_WIDTH-1:0] w_row_ext;
    logic [ADDR_WIDTH-1:0] w_col_ext;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_in_range;

    logic                  r_valid;
    logic                  r_in_range;
    logic [ADDR_WIDTH-1:0] r_addr;

    assign w_row_ext  = {{(ADDR_WIDTH-5){1'b0}}, i_row};
    assign w_col_ext  = {{(ADDR_WIDTH-7){1'b0}}, i_col};
    assign w_in_range = (i_col < c_cols) && (i_row < c_rows);

    generate
        if (COLS == 80) begin : g_shift_add
            assign w_addr = (w_row_ext << 6) + (w_row_ext << 4) + w_col_ext;
        end else begin : g_mult
            assign w_addr = w_row_ext * ADDR_WIDTH'(COLS) + w_col_ext;
        end
    endgenerate

    // The address only moves on in-range fetches so it can double as the
    // idle value of the RAM address bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_in_range <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_valid    <= i_fetch;
            r_in_range <= w_in_range;
            if (i_fetch && w_in_range) begin
                r_addr <= w_addr;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_in_range = r_in_range;
    assign o_addr     = r_addr;

endmodule
`default_nettype wire

// File: rtl/text_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : text_ram_arbiter
// Description : Shares the character RAM between display fetch and host port.
// Revision    : 1.0
// ============================================================================
module text_ram_arbiter
    import text_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch,
    input  logic [6:0]            fetch_col,
    input  logic [4:0]            fetch_row,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_char,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  host_write,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic                  w_cell_valid;
    logic                  w_cell_in_range;
    logic [ADDR_WIDTH-1:0] w_cell_addr;
    logic                  w_accept;
    logic                  w_host_issue;
    slot_e                 w_slot;

    logic                  r_alive;
    logic                  r_full;
    logic                  r_hold_write;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic [DATA_WIDTH-1:0] r_hold_wdata;
    logic                  r_last_disp;
    tag_e                  r_tag;
    logic                  r_oor;
    logic                  r_fetch_valid;
    logic [DATA_WIDTH-1:0] r_fetch_char;
    logic                  r_host_rvalid;
    logic [DATA_WIDTH-1:0] r_host_rdata;

    cell_address u_cell_address (
        .clk        (clk),
        .rst        (reset),
        .i_fetch    (fetch),
        .i_col      (fetch_col),
        .i_row      (fetch_row),
        .o_valid    (w_cell_valid),
        .o_in_range (w_cell_in_range),
        .o_addr     (w_cell_addr)
    );

    always_comb begin
        w_slot = SLOT_IDLE;
        if (w_cell_valid && w_cell_in_range) begin
            w_slot = SLOT_DISP;
        end else if (r_full) begin
            w_slot = r_hold_write ? SLOT_HOST_WR : SLOT_HOST_RD;
        end
    end

    assign w_host_issue = (w_slot == SLOT_HOST_RD) || (w_slot == SLOT_HOST_WR);
    assign w_accept     = host_valid && host_ready;

    // r_alive keeps host_ready low throughout reset and until the first edge.
    assign host_ready = r_alive && !r_full;

    assign ram_en    = (w_slot != SLOT_IDLE);
    assign ram_we    = (w_slot == SLOT_HOST_WR);
    assign ram_addr  = ((w_slot == SLOT_DISP) || ((w_slot == SLOT_IDLE) && r_last_disp))
                       ? w_cell_addr : r_hold_addr;
    assign ram_wdata = r_hold_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive      <= 1'b0;
            r_full       <= 1'b0;
            r_hold_write <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
            r_last_disp  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_host_issue) begin
                r_full <= 1'b0;
            end
            if (w_accept) begin
                r_full       <= 1'b1;
                r_hold_write <= host_write;
                r_hold_addr  <= host_addr;
                if (host_write) begin
                    r_hold_wdata <= host_wdata;
                end
            end
            if (w_slot == SLOT_DISP) begin
                r_last_disp <= 1'b1;
            end else if (w_host_issue) begin
                r_last_disp <= 1'b0;
            end
        end
    end

    // Return path: the tag travels with each read so ram_rdata is steered
    // to the right output one cycle after the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag         <= TAG_NONE;
            r_oor         <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_char  <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            case (w_slot)
                SLOT_DISP:    r_tag <= TAG_DISP;
                SLOT_HOST_RD: r_tag <= TAG_HOST;
                default:      r_tag <= TAG_NONE;
            endcase
            r_oor         <= w_cell_valid && !w_cell_in_range;
            r_fetch_valid <= (r_tag == TAG_DISP) || r_oor;
            if (r_tag == TAG_DISP) begin
                r_fetch_char <= ram_rdata;
            end else if (r_oor) begin
                r_fetch_char <= SPACE_CHAR;
            end
            r_host_rvalid <= (r_tag == TAG_HOST);
            if (r_tag == TAG_HOST) begin
                r_host_rdata <= ram_rdata;
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_char  = r_fetch_char;
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_text_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_ram_arbiter
// Description : Scoreboard bench with a RAM model for text_ram_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_text_ram_arbiter;
    import text_ram_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch = 1'b0;
    logic [6:0]  fetch_col = '0;
    logic [4:0]  fetch_row = '0;
    logic        fetch_valid;
    logic [7:0]  fetch_char;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic        host_write = 1'b0;
    logic [10:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    text_ram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .fetch_col   (fetch_col),
        .fetch_row   (fetch_row),
        .fetch_valid (fetch_valid),
        .fetch_char  (fetch_char),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_write  (host_write),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data one cycle after the enable.
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] data; } fexp_t;
    typedef struct { int acc; logic [7:0] data; bit chk_wait; } hexp_t;

    logic [7:0] ref_mem [0:2047];
    fexp_t      fq[$];
    hexp_t      hq[$];
    bit         claimed[int];
    bit         sweep_mode = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    // Host issues in the first cycle after acceptance not claimed by display.
    function automatic int issue_cycle(input int acc);
        int c;
        c = acc + 1;
        while (claimed.exists(c)) c++;
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit f, input int col, input int row, input bit hv,
                        input bit hw, input int addr, input logic [7:0] wd, output bit acc);
        fexp_t fe;
        hexp_t he;
        @(negedge clk);
        acc       = 1'b0;
        fetch     = f;
        fetch_col = 7'(col);
        fetch_row = 5'(row);
        if (f) begin
            fe.cyc = cyc + 3;
            if (col < 80 && row < 24) begin
                fe.data = ref_mem[row * 80 + col];
                claimed[cyc + 1] = 1'b1;
            end else begin
                fe.data = 8'h20;
            end
            fq.push_back(fe);
        end
        host_valid = 1'b0;
        if (hv && host_ready) begin
            acc        = 1'b1;
            host_valid = 1'b1;
            host_write = hw;
            host_addr  = 11'(addr);
            host_wdata = wd;
            if (hw) begin
                ref_mem[addr] = wd;
            end else begin
                he.acc      = cyc;
                he.data     = ref_mem[addr];
                he.chk_wait = sweep_mode;
                hq.push_back(he);
            end
        end
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0, 0, 8'h00, a);
    endtask

    task automatic host_req(input bit hw, input int addr, input logic [7:0] wd);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 50 && !a; k++) step(1'b0, 0, 0, 1'b1, hw, addr, wd, a);
        check("host_accept", 64'(a), 64'd1);
    endtask

    task automatic host_traffic_step(input bit f, input int col, input int row);
        bit a;
        bit hw;
        int addr;
        hw   = ($urandom_range(0, 1) == 1);
        addr = hw ? (1920 + $urandom_range(0, 127)) : $urandom_range(0, 2047);
        step(f, col, row, 1'b1, hw, addr, 8'($urandom), a);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    fexp_t m_fe;
    hexp_t m_he;
    int    m_iss;
    always @(negedge clk) begin
        if (!reset) begin
            if (fetch_valid) begin
                n_checks++;
                if (fq.size() == 0) begin
                    n_errors++;
                    $display("FAIL fetch_unexpected: got fetch_valid char %02h at cycle %0d, expected none",
                             fetch_char, cyc);
                end else begin
                    m_fe = fq.pop_front();
                    if (m_fe.cyc != cyc || m_fe.data !== fetch_char) begin
                        n_errors++;
                        $display("FAIL fetch_char: got %02h at cycle %0d, expected %02h at cycle %0d",
                                 fetch_char, cyc, m_fe.data, m_fe.cyc);
                    end
                end
            end
            if (host_rvalid) begin
                n_checks++;
                if (hq.size() == 0) begin
                    n_errors++;
                    $display("FAIL host_unexpected: got host_rvalid data %02h at cycle %0d, expected none",
                             host_rdata, cyc);
                end else begin
                    m_he  = hq.pop_front();
                    m_iss = issue_cycle(m_he.acc);
                    if (m_iss + 2 != cyc || m_he.data !== host_rdata) begin
                        n_errors++;
                        $display("FAIL host_rdata: got %02h at cycle %0d, expected %02h at cycle %0d",
                                 host_rdata, cyc, m_he.data, m_iss + 2);
                    end
                    if (m_he.chk_wait) begin
                        n_checks++;
                        if (m_iss - (m_he.acc + 1) > 1) begin
                            n_errors++;
                            $display("FAIL host_wait: got %0d cycles, expected at most 1",
                                     m_iss - (m_he.acc + 1));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion by time limit, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        bit         a;
        int         d;
        for (int i = 0; i < 2048; i++) begin
            v          = 8'($urandom);
            mem[i]    <= v;
            ref_mem[i] = v;
        end
        mem[11'h0A5]    <= 8'h41;
        ref_mem[11'h0A5] = 8'h41;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({fetch_valid, fetch_char, host_ready, host_rvalid, host_rdata,
                   ram_en, ram_we, ram_addr, ram_wdata}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("ready_before_edge", 64'(host_ready), 64'd0);
        @(posedge clk);
        #1 check("ready_after_release", 64'(host_ready), 64'd1);

        // Single display fetch of row 2, col 5
        step(1'b1, 5, 2, 1'b0, 1'b0, 0, 8'h00, a);
        idle(1);
        check("disp_slot_addr", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 11'h0A5}));
        idle(4);

        // Host write then read back at the top address
        host_req(1'b1, 11'h7FF, 8'h5A);
        idle(1);
        check("host_wr_slot", 64'({ram_en, ram_we, ram_addr, ram_wdata}),
              64'({1'b1, 1'b1, 11'h7FF, 8'h5A}));
        host_req(1'b0, 11'h7FF, 8'h00);
        idle(5);

        // Fetch and host read accepted at the same edge
        step(1'b1, 0, 1, 1'b1, 1'b0, 11'h100, 8'h00, a);
        check("simul_accept", 64'(a), 64'd1);
        idle(1);
        check("simul_disp_slot", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 11'd80}));
        idle(1);
        check("simul_host_slot", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 11'h100}));
        idle(5);

        // Out-of-range fetch gives its slot to the waiting host
        step(1'b1, 80, 3, 1'b1, 1'b0, 11'h123, 8'h00, a);
        idle(1);
        check("oor_host_slot", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 11'h123}));
        idle(1);
        check("oor_no_disp_slot", 64'(ram_en), 64'd0);
        idle(5);

        // Back-to-back fetches push the host back
        step(1'b1, 0, 0, 1'b1, 1'b0, 11'h055, 8'h00, a);
        step(1'b1, 1, 0, 1'b0, 1'b0, 0, 8'h00, a);
        step(1'b1, 79, 23, 1'b0, 1'b0, 0, 8'h00, a);
        idle(8);

        // Full-frame sweep with continuous host traffic
        sweep_mode = 1'b1;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 80; c++) begin
                host_traffic_step(1'b1, c, r);
                repeat (9) host_traffic_step(1'b0, 0, 0);
            end
        end
        sweep_mode = 1'b0;
        idle(10);

        // Random fetches, including out-of-range and bursts
        for (int i = 0; i < 400; i++) begin
            host_traffic_step($urandom_range(0, 3) == 0, $urandom_range(0, 127), $urandom_range(0, 31));
        end
        idle(12);
        check("fetch_queue_drained", 64'(fq.size()), 64'd0);
        check("host_queue_drained", 64'(hq.size()), 64'd0);

        // Reset between host issue and read return
        host_req(1'b0, 11'h200, 8'h00);
        idle(1);
        check("pre_reset_issue", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 11'h200}));
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("reset_mid_read",
              64'({fetch_valid, fetch_char, host_ready, host_rvalid, host_rdata,
                   ram_en, ram_we, ram_addr, ram_wdata}), 64'd0);
        hq.delete();
        d = cyc;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("ready_after_mid_reset", 64'(host_ready), 64'd1);
        idle(8);
        check("no_stale_rvalid_window", 64'(cyc - d > 8), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
